pipe_hazard_ctrl: RTL

Central stall/flush controller for the five-stage core. It generates the per-segment `stall`/`refresh` pairs consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers, and owns the sequencing state behind them: load-use detection, the multicycle divide busy counter, the data-memory request handshake, and instruction-fetch cancellation after an exception/eret flush. Every segment register gives `refresh` priority over `stall`, and the encodings below are built on that.

---
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the central stall/flush controller.
// slave = controller side, master = pipeline side.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_ren;
  logic       id_rt_ren;
  logic       ex_load;
  logic       ex_regwen;
  logic [4:0] ex_wreg;
  logic       ex_div;
  logic       mem_data_en;
  logic       data_addr_ok;
  logic       data_data_ok;
  logic       inst_wait;
  logic       inst_data_ok;
  logic       mem_flush;

  logic       data_req;
  logic       div_start;
  logic       div_done;
  logic       inst_cancel;
  logic       pc_flush;
  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_stall;
  logic       exmem_stall;
  logic       ifid_refresh;
  logic       idex_refresh;
  logic       exmem_refresh;
  logic       memwb_refresh;

  modport slave (
    input  id_rs, id_rt, id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_wreg, ex_div,
           mem_data_en, data_addr_ok, data_data_ok, inst_wait, inst_data_ok, mem_flush,
    output data_req, div_start, div_done, inst_cancel, pc_flush,
           pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_refresh, idex_refresh, exmem_refresh, memwb_refresh
  );

  modport master (
    output id_rs, id_rt, id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_wreg, ex_div,
           mem_data_en, data_addr_ok, data_data_ok, inst_wait, inst_data_ok, mem_flush,
    input  data_req, div_start, div_done, inst_cancel, pc_flush,
           pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_refresh, idex_refresh, exmem_refresh, memwb_refresh
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage core: data-bus handshake,
// iterative-divide busy tracking, load-use interlock and post-flush fetch cancel.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 33
) (
  input  logic               clk,
  input  logic               resetn,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {D_IDLE, D_ADDR, D_DATA} dstate_t;
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mstate_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  dstate_t    d_q;
  mstate_t    m_q;
  logic [5:0] cnt_q;
  logic       flush_pending_q;
  logic       inst_cancel_q;

  logic dwait;
  logic divbusy;
  logic lu;
  logic flush;
  logic rs_hit;
  logic rt_hit;

  assign dwait   = ((d_q == D_IDLE) & hz.mem_data_en) | (d_q == D_ADDR) |
                   ((d_q == D_DATA) & ~hz.data_data_ok);
  assign divbusy = ((m_q == M_IDLE) & hz.ex_div) | (m_q == M_BUSY);
  // A flush is only taken with no data transaction in flight; otherwise it waits.
  assign flush   = (hz.mem_flush | flush_pending_q) & (d_q == D_IDLE);

  assign rs_hit = hz.id_rs_ren & (hz.id_rs == hz.ex_wreg);
  assign rt_hit = hz.id_rt_ren & (hz.id_rt == hz.ex_wreg);
  assign lu     = hz.ex_load & hz.ex_regwen & (hz.ex_wreg != 5'd0) & (rs_hit | rt_hit);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      d_q             <= D_IDLE;
      m_q             <= M_IDLE;
      cnt_q           <= 6'd0;
      flush_pending_q <= 1'b0;
      inst_cancel_q   <= 1'b0;
    end else begin
      case (d_q)
        D_IDLE:  if (hz.mem_data_en) d_q <= hz.data_addr_ok ? D_DATA : D_ADDR;
        D_ADDR:  if (hz.data_addr_ok) d_q <= D_DATA;
        D_DATA:  if (hz.data_data_ok) d_q <= D_IDLE;
        default: d_q <= D_IDLE;
      endcase

      flush_pending_q <= flush ? 1'b0 : (flush_pending_q | hz.mem_flush);

      if (flush) begin
        m_q   <= M_IDLE;
        cnt_q <= 6'd0;
      end else begin
        case (m_q)
          M_IDLE: if (hz.ex_div) begin
            m_q   <= M_BUSY;
            cnt_q <= DIV_LOAD;
          end
          M_BUSY: begin
            if (cnt_q == 6'd0) m_q <= M_DONE;
            else               cnt_q <= cnt_q - 6'd1;
          end
          // Hold DONE while MEM stalls so the still-present DIV is not restarted.
          M_DONE:  if (!dwait) m_q <= M_IDLE;
          default: m_q <= M_IDLE;
        endcase
      end

      if (hz.inst_data_ok)         inst_cancel_q <= 1'b0;
      else if (flush & hz.inst_wait) inst_cancel_q <= 1'b1;
    end
  end

  always_comb begin
    hz.data_req      = 1'b0;
    hz.div_start     = 1'b0;
    hz.div_done      = 1'b0;
    hz.inst_cancel   = 1'b0;
    hz.pc_flush      = 1'b0;
    hz.pc_stall      = 1'b0;
    hz.ifid_stall    = 1'b0;
    hz.idex_stall    = 1'b0;
    hz.exmem_stall   = 1'b0;
    hz.ifid_refresh  = 1'b0;
    hz.idex_refresh  = 1'b0;
    hz.exmem_refresh = 1'b0;
    hz.memwb_refresh = 1'b0;
    if (resetn) begin
      hz.data_req    = ((d_q == D_IDLE) & hz.mem_data_en) | (d_q == D_ADDR);
      hz.div_start   = (m_q == M_IDLE) & hz.ex_div & ~flush;
      hz.div_done    = (m_q == M_DONE);
      hz.inst_cancel = inst_cancel_q;
      // Segment registers favour refresh over stall, so each level only needs
      // to refresh the segment right behind the stalled ones.
      if (flush) begin
        hz.pc_flush      = 1'b1;
        hz.ifid_refresh  = 1'b1;
        hz.idex_refresh  = 1'b1;
        hz.exmem_refresh = 1'b1;
        hz.memwb_refresh = 1'b1;
      end else if (dwait) begin
        hz.pc_stall      = 1'b1;
        hz.ifid_stall    = 1'b1;
        hz.idex_stall    = 1'b1;
        hz.exmem_stall   = 1'b1;
        hz.memwb_refresh = 1'b1;
      end else if (divbusy) begin
        hz.pc_stall      = 1'b1;
        hz.ifid_stall    = 1'b1;
        hz.idex_stall    = 1'b1;
        hz.exmem_refresh = 1'b1;
      end else if (lu) begin
        hz.pc_stall      = 1'b1;
        hz.ifid_stall    = 1'b1;
        hz.idex_refresh  = 1'b1;
      end else if (hz.inst_wait | inst_cancel_q) begin
        hz.pc_stall      = 1'b1;
        hz.ifid_refresh  = 1'b1;
      end
    end
  end

endmodule
